// File: rtl/serial_sum_collector_pkg.sv
// Shared constants for the serial sum collector: FSM encoding, default word
// width and the bit-counter width helper.
package serial_sum_collector_pkg;

  localparam int SSC_WIDTH = 8;
  localparam int STATE_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_COLLECT = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD    = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_sum_collector_shift_reg.sv
// Right shift register: new bit enters at the MSB, clear has priority over enable.
module ssc_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Collects LSB-first sum bits from an upstream serial adder into a WIDTH-bit
// word plus final carry, and hands each word off over a valid/ready port.
module serial_sum_collector
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH = SSC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic               z_in,
  input  logic               cout_in,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_word,
  output logic               out_carry,
  output logic [7:0]         word_cnt,
  output logic [STATE_W-1:0] fsm_state
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   sr_q;
  logic               accept;
  logic               last_bit;
  logic               handoff;
  logic               sr_clear;

  // Handshakes: a bit transfers on a cycle with in_valid && in_ready (and no
  // start); a word transfers on out_valid && out_ready. Neither side may
  // withdraw a raised valid, and out_word/out_carry stay stable while valid.
  assign in_ready  = (state == ST_COLLECT);
  assign out_valid = (state == ST_HOLD);
  assign fsm_state = state;

  assign accept   = in_ready && in_valid && !start;
  assign last_bit = accept && (bit_cnt == CNT_W'(WIDTH - 1));
  assign handoff  = out_valid && out_ready;
  assign sr_clear = start && ((state == ST_IDLE) || (state == ST_COLLECT) || handoff);

  ssc_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk   (clk),
    .reset (reset),
    .clear (sr_clear),
    .en    (accept),
    .din   (z_in),
    .q     (sr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      out_word  <= '0;
      out_carry <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_COLLECT;
            bit_cnt <= '0;
          end
        end
        ST_COLLECT: begin
          if (start) begin
            bit_cnt <= '0;
          end else if (last_bit) begin
            // The final bit is merged here rather than read back from the register.
            out_word  <= {z_in, sr_q[WIDTH-1:1]};
            out_carry <= cout_in;
            bit_cnt   <= '0;
            state     <= ST_HOLD;
          end else if (accept) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            word_cnt <= word_cnt + 8'd1;
            bit_cnt  <= '0;
            state    <= start ? ST_COLLECT : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_sum_collector.md
SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

Interface
REQ-001 Parameter: WIDTH, 8, number of result bits assembled into one output word (legal range 2..16).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins (or restarts) collection of a word.
REQ-005 in_valid  input  1  z_in/cout_in carry a valid result bit this cycle.
REQ-006 z_in  input  1  sum bit from the upstream adder stage, LSB first.
REQ-007 cout_in  input  1  carry-out from the upstream adder stage for the current bit.
REQ-008 in_ready  output  1  block accepts a bit this cycle.
REQ-009 out_valid  output  1  out_word/out_carry hold a completed word.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 out_word  output  WIDTH  assembled sum word, bit 0 = first accepted bit.
REQ-012 out_carry  output  1  cout_in captured with the last (MSB) bit.
REQ-013 word_cnt  output  8  count of words handed off; wraps 255 -> 0.

Function
REQ-014 FSM states: IDLE, COLLECT, HOLD; encoding lives in the shared package.
REQ-015 IDLE: in_ready=0, out_valid=0; start -> COLLECT with bit counter cleared and shift register cleared.
REQ-016 COLLECT: in_ready=1; a bit is accepted when in_valid=1; accepted z_in enters the MSB and the register shifts right by one.
REQ-017 COLLECT: bit counter (width ceil(log2(WIDTH))+1) increments per accepted bit; cycles with in_valid=0 hold all state.
REQ-018 On acceptance of bit WIDTH-1: out_word = full register including that bit, out_carry = that cycle's cout_in, -> HOLD next cycle; out_valid=1 the cycle after the last bit (latency 1).
REQ-019 HOLD: in_ready=0, out_valid=1, out_word/out_carry stable; in_valid ignored.
REQ-020 HOLD with out_ready=1: handshake completes, word_cnt increments, -> IDLE, out_valid=0 next cycle.
REQ-021 HOLD with out_ready=1 and start=1 same cycle: handshake completes, word_cnt increments, -> COLLECT with cleared counter.
REQ-022 HOLD with out_ready=0 and start=1: start ignored; word is never dropped.
REQ-023 COLLECT with start=1: partial word discarded, counter and register cleared, stay in COLLECT; in_valid bit in that cycle is discarded.
REQ-024 out_word/out_carry retain last handed-off values in IDLE and COLLECT (only updated on word completion).
REQ-025 word_cnt wraps modulo 256 without flag.

Reset
REQ-026 reset asserted: state=IDLE, in_ready=0, out_valid=0, out_word=0, out_carry=0, word_cnt=0, bit counter=0, immediately and independent of clk.
REQ-027 reset mid-COLLECT or mid-HOLD discards all partial/pending data; first post-reset action requires start.

Structure
REQ-028 Shared package holds state encoding constants and the default WIDTH.
REQ-029 One sub-module: ssc_shift_reg (WIDTH-bit right shift register with clear and enable); FSM, counters and handshake stay in the top.

Verification
REQ-030 reset, start, 8 bits in_valid=1 z_in=1,0,1,1,0,0,1,0 cout_in last=1, out_ready=1 -> out_valid one cycle after last bit, out_word=8'h4D, out_carry=1, word_cnt=1.
REQ-031 Same stream with in_valid deasserted every other cycle -> identical out_word=8'h4D, completion after 16 cycles.
REQ-032 Word complete, out_ready=0 for 5 cycles with in_valid=1 and start pulsed -> out_valid held, out_word stable, in_ready=0, word_cnt unchanged until out_ready=1.
REQ-033 start, 3 bits accepted, start again, then 8 bits all 1s -> out_word=8'hFF (partial discarded).
REQ-034 reset asserted asynchronously between clk edges mid-COLLECT -> all outputs 0 before next edge; bits without start ignored.
REQ-035 256 back-to-back words with start in handshake cycle -> word_cnt wraps to 0, no cycle gap between words.
